uart_cmd_decoder: RTL

UART_CMD_DECODER -- requirements
Module: uart_cmd_decoder

---
 rtl/uart_cmd_pkg.sv | 26 ++
 rtl/cmd_timeout_counter.sv | 28 ++
 rtl/uart_cmd_decoder.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/uart_cmd_pkg.sv
// Shared constants and state encoding for the UART register-command decoder.
package uart_cmd_pkg;

    localparam logic [7:0] SYNC_BYTE   = 8'hA5;
    localparam logic [7:0] CMD_WRITE   = 8'h01;
    localparam logic [7:0] CMD_READ    = 8'h02;

    localparam logic [7:0] RSP_WR_OK   = 8'h4B;
    localparam logic [7:0] RSP_BAD_CMD = 8'h3F;
    localparam logic [7:0] RSP_TIMEOUT = 8'h21;

    // uart_send IDLE lags DATA_READY, so it is not trusted right after a pulse
    localparam logic [1:0] RESP_HOLDOFF = 2'd2;

    typedef enum logic [2:0] {
        ST_HUNT,
        ST_CMD,
        ST_ADDR,
        ST_DH,
        ST_DL,
        ST_EXEC,
        ST_RESP,
        ST_RESP_WAIT
    } state_e;

endpackage

// File: rtl/cmd_timeout_counter.sv
// Saturating cycle counter; expired stays high once LIMIT enabled cycles elapse
// since the last clear. Used for both inter-byte gaps and register-ack waits.
module cmd_timeout_counter #(
    parameter int unsigned LIMIT = 5000000
) (
    input  logic CLK,
    input  logic RST,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CW = $clog2(LIMIT + 1);

    logic [CW-1:0] count;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (enable && !expired)
            count <= count + CW'(1);
    end

    assign expired = (count == CW'(LIMIT));

endmodule

// File: rtl/uart_cmd_decoder.sv
// Decodes A5-synced UART command frames into register read/write requests and
// streams the response bytes back through uart_send.
module uart_cmd_decoder
    import uart_cmd_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 5000000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [7:0]  RX_DATA,
    input  logic        RX_READY,
    output logic [7:0]  REG_ADDR,
    output logic [15:0] REG_WDATA,
    output logic        REG_WE,
    output logic        REG_RE,
    input  logic        REG_ACK,
    input  logic [15:0] REG_RDATA,
    output logic [7:0]  TX_DATA,
    output logic        TX_VALID,
    input  logic        TX_IDLE
);

    state_e      state, state_nxt;
    logic        rx_prev;
    logic        rx_pulse;
    logic        cmd_ok;
    logic        is_write;
    logic        req_issued;
    logic        req_on;
    logic [7:0]  resp0, resp1;
    logic [1:0]  resp_cnt;
    logic [1:0]  wait_cnt;
    logic        gap_state;
    logic        tmr_clr, tmr_en, tmo;

    assign rx_pulse  = RX_READY & ~rx_prev;
    assign req_on    = REG_WE | REG_RE;
    assign cmd_ok    = (RX_DATA == CMD_WRITE) || (RX_DATA == CMD_READ);
    assign gap_state = (state == ST_CMD) || (state == ST_ADDR) ||
                       (state == ST_DH)  || (state == ST_DL);
    assign tmr_en    = gap_state || (state == ST_EXEC);
    // Any state change restarts timing, which arms the ack timer on EXEC entry
    assign tmr_clr   = rx_pulse || (state_nxt != state);

    cmd_timeout_counter #(
        .LIMIT   (TIMEOUT_CYCLES)
    ) u_tmr (
        .CLK     (CLK),
        .RST     (RST),
        .clear   (tmr_clr),
        .enable  (tmr_en),
        .expired (tmo)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)
            state <= ST_HUNT;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_HUNT:
                if (rx_pulse && (RX_DATA == SYNC_BYTE)) state_nxt = ST_CMD;
            ST_CMD:
                if (rx_pulse)  state_nxt = cmd_ok ? ST_ADDR : ST_RESP;
                else if (tmo)  state_nxt = ST_HUNT;
            ST_ADDR:
                if (rx_pulse)  state_nxt = is_write ? ST_DH : ST_EXEC;
                else if (tmo)  state_nxt = ST_HUNT;
            ST_DH:
                if (rx_pulse)  state_nxt = ST_DL;
                else if (tmo)  state_nxt = ST_HUNT;
            ST_DL:
                if (rx_pulse)  state_nxt = ST_EXEC;
                else if (tmo)  state_nxt = ST_HUNT;
            ST_EXEC:
                if ((req_on && REG_ACK) || tmo) state_nxt = ST_RESP;
            ST_RESP:
                if (TX_IDLE) state_nxt = ST_RESP_WAIT;
            ST_RESP_WAIT:
                if ((wait_cnt == 2'd0) && TX_IDLE)
                    state_nxt = (resp_cnt != 2'd0) ? ST_RESP : ST_HUNT;
            default:
                state_nxt = ST_HUNT;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rx_prev    <= 1'b1;
            is_write   <= 1'b0;
            req_issued <= 1'b0;
            REG_ADDR   <= 8'h00;
            REG_WDATA  <= 16'h0000;
            REG_WE     <= 1'b0;
            REG_RE     <= 1'b0;
            TX_DATA    <= 8'h00;
            TX_VALID   <= 1'b0;
            resp0      <= 8'h00;
            resp1      <= 8'h00;
            resp_cnt   <= 2'd0;
            wait_cnt   <= 2'd0;
        end else begin
            rx_prev  <= RX_READY;
            TX_VALID <= 1'b0;
            if (state != ST_EXEC) req_issued <= 1'b0;
            case (state)
                ST_CMD:
                    if (rx_pulse) begin
                        if (cmd_ok) begin
                            is_write <= (RX_DATA == CMD_WRITE);
                        end else begin
                            resp0    <= RSP_BAD_CMD;
                            resp_cnt <= 2'd1;
                        end
                    end
                ST_ADDR:
                    if (rx_pulse) REG_ADDR <= RX_DATA;
                ST_DH:
                    if (rx_pulse) REG_WDATA[15:8] <= RX_DATA;
                ST_DL:
                    if (rx_pulse) REG_WDATA[7:0] <= RX_DATA;
                ST_EXEC: begin
                    if (req_on && REG_ACK) begin
                        REG_WE <= 1'b0;
                        REG_RE <= 1'b0;
                        if (is_write) begin
                            resp0    <= RSP_WR_OK;
                            resp_cnt <= 2'd1;
                        end else begin
                            resp0    <= REG_RDATA[15:8];
                            resp1    <= REG_RDATA[7:0];
                            resp_cnt <= 2'd2;
                        end
                    end else if (tmo) begin
                        REG_WE   <= 1'b0;
                        REG_RE   <= 1'b0;
                        resp0    <= RSP_TIMEOUT;
                        resp_cnt <= 2'd1;
                    end else if (!req_issued) begin
                        REG_WE     <= is_write;
                        REG_RE     <= ~is_write;
                        req_issued <= 1'b1;
                    end
                end
                ST_RESP:
                    if (TX_IDLE) begin
                        TX_DATA  <= resp0;
                        TX_VALID <= 1'b1;
                        resp0    <= resp1;
                        resp_cnt <= resp_cnt - 2'd1;
                        wait_cnt <= RESP_HOLDOFF;
                    end
                ST_RESP_WAIT:
                    if (wait_cnt != 2'd0) wait_cnt <= wait_cnt - 2'd1;
                default: ;
            endcase
        end
    end

endmodule
